pc_unit: RTL

Program-counter unit for the single-cycle RISC-V core. It replaces the standalone PC+4 incrementer with a parametrised block that:
- holds the PC register;
- steps by 4, or by 2 when compressed instructions are enabled;
- selects among sequential, branch/jump, trap and mret targets by fixed priority;
- detects misaligned redirect targets;
- counts retired instructions.

It sits between the control/branch logic and the instruction memory address port.

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_incrementer.sv | 17 +
 rtl/pc_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

  // Next-PC source, resolved by fixed priority each cycle.
  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BRANCH,
    PC_TRAP,
    PC_MRET,
    PC_HOLD,
    PC_MISALIGN
  } pc_sel_e;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } pc_state_e;

  localparam int unsigned STEP_FULL = 4;
  localparam int unsigned STEP_HALF = 2;

  // Low address bits that must be zero for a legal instruction address.
  function automatic logic [1:0] align_bits(input bit c_ext);
    return c_ext ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Sequential-successor adder: pc + 2 or pc + 4, modulo 2^XLEN.
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            half_i,
  output logic [XLEN-1:0] pc_step_o
);

  // Select the step size and add; carry out is intentionally dropped.
  always_comb begin
    pc_step_o = pc_i + (half_i ? XLEN'(STEP_HALF) : XLEN'(STEP_FULL));
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, prioritised next-PC select,
// misaligned-redirect detection and retired-instruction counter.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter bit             C_EXT        = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            instr_compressed_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_step_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] badaddr_o,
  output logic [63:0]     instret_o
);

  localparam logic [XLEN-1:0] AlignMask = XLEN'(align_bits(C_EXT));

  pc_state_e       state_q, state_d;
  pc_sel_e         sel;
  logic            run;
  logic            half;
  logic            br_misaligned;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] badaddr_q, badaddr_d;
  logic            misaligned_q, misaligned_d;
  logic [63:0]     instret_q, instret_d;
  logic [XLEN-1:0] pc_step;

  assign half = C_EXT && instr_compressed_i;

  pc_incrementer #(
    .XLEN (XLEN)
  ) u_incr (
    .pc_i      (pc_q),
    .half_i    (half),
    .pc_step_o (pc_step)
  );

  // State register plus all datapath flops; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      badaddr_q    <= '0;
      misaligned_q <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      badaddr_q    <= badaddr_d;
      misaligned_q <= misaligned_d;
      instret_q    <= instret_d;
    end
  end

  // BOOT lasts a single clock, RUN is left only through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // FSM output: inputs only take effect in RUN.
  always_comb begin
    run = (state_q == ST_RUN);
  end

  // Fixed-priority next-PC source select.
  always_comb begin
    br_misaligned = |(branch_target_i & AlignMask);
    if (trap_i)                               sel = PC_TRAP;
    else if (mret_i)                          sel = PC_MRET;
    else if (branch_taken_i && !br_misaligned) sel = PC_BRANCH;
    else if (branch_taken_i)                  sel = PC_MISALIGN;
    else if (stall_i)                         sel = PC_HOLD;
    else                                      sel = PC_SEQ;
  end

  // Next-state datapath; BOOT freezes everything.
  always_comb begin
    pc_d         = pc_q;
    badaddr_d    = badaddr_q;
    misaligned_d = 1'b0;
    instret_d    = instret_q;
    if (run) begin
      unique case (sel)
        PC_TRAP:     pc_d = TRAP_VECTOR;
        PC_MRET:     pc_d = mepc_i & ~AlignMask;
        PC_BRANCH:   pc_d = branch_target_i;
        PC_MISALIGN: pc_d = TRAP_VECTOR;
        PC_HOLD:     pc_d = pc_q;
        PC_SEQ:      pc_d = pc_step;
        default:     pc_d = pc_q;
      endcase
      if (sel == PC_MISALIGN) begin
        misaligned_d = 1'b1;
        badaddr_d    = branch_target_i;
      end
      // Only instructions that complete normally retire.
      if (sel == PC_SEQ || sel == PC_BRANCH || sel == PC_MRET) begin
        instret_d = instret_q + 64'd1;
      end
    end
  end

  assign pc_o         = pc_q;
  assign pc_step_o    = pc_step;
  assign pc_next_o    = pc_d;
  assign misaligned_o = misaligned_q;
  assign badaddr_o    = badaddr_q;
  assign instret_o    = instret_q;

endmodule
